// File: rtl/mem_arbiter.sv
// Arbitrates the core's instruction and data request ports onto one memory port,
// tracking the owner of each outstanding transaction to route responses back.
module mem_arbiter #(
  parameter int unsigned Xlen            = 32,
  parameter int unsigned Ilen            = 32,
  parameter int unsigned OutstandingLog2 = 2,
  parameter int unsigned StarveLimit     = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,

  input  logic              inst_valid_i,
  output logic              inst_ready_o,
  input  logic [Xlen-1:0]   inst_addr_i,
  input  logic [Ilen-1:0]   inst_wdata_i,
  input  logic [Ilen/8-1:0] inst_wmask_i,
  output logic [Ilen-1:0]   inst_rdata_o,
  output logic              inst_rvalid_o,

  input  logic              data_valid_i,
  output logic              data_ready_o,
  input  logic [Xlen-1:0]   data_addr_i,
  input  logic [Ilen-1:0]   data_wdata_i,
  input  logic [Ilen/8-1:0] data_wmask_i,
  output logic [Ilen-1:0]   data_rdata_o,
  output logic              data_rvalid_o,

  output logic              mem_valid_o,
  input  logic              mem_ready_i,
  output logic [Xlen-1:0]   mem_addr_o,
  output logic [Ilen-1:0]   mem_wdata_o,
  output logic [Ilen/8-1:0] mem_wmask_o,
  input  logic [Ilen-1:0]   mem_rdata_i,
  input  logic              mem_rvalid_i,

  output logic              err_o
);

  localparam int unsigned Depth = 1 << OutstandingLog2;

  typedef enum logic [1:0] {
    HoldNone = 2'd0,
    HoldInst = 2'd1,
    HoldData = 2'd2
  } hold_e;

  typedef enum logic [1:0] {
    SelNone,
    SelInst,
    SelData
  } sel_e;

  hold_e                      hold_q, hold_d;
  logic [Depth-1:0]           owner_q, owner_d;
  logic [OutstandingLog2-1:0] wr_ptr_q, wr_ptr_d;
  logic [OutstandingLog2-1:0] rd_ptr_q, rd_ptr_d;
  logic [OutstandingLog2:0]   count_q, count_d;
  logic [3:0]                 starve_q, starve_d;
  logic                       err_q, err_d;

  sel_e sel;
  logic full;
  logic accept;
  logic have_outstanding;
  logic pop;
  logic head_owner;

  // A full tracker blocks selection outright, even if a pop lands this cycle.
  always_comb begin
    full = (count_q == (OutstandingLog2 + 1)'(Depth));
    sel  = SelNone;
    if (!full) begin
      if (hold_q == HoldInst) begin
        sel = SelInst;
      end else if (hold_q == HoldData) begin
        sel = SelData;
      end else if (inst_valid_i && data_valid_i) begin
        sel = (starve_q == 4'(StarveLimit)) ? SelInst : SelData;
      end else if (inst_valid_i) begin
        sel = SelInst;
      end else if (data_valid_i) begin
        sel = SelData;
      end
    end
  end

  always_comb begin
    mem_valid_o  = 1'b0;
    inst_ready_o = 1'b0;
    data_ready_o = 1'b0;
    mem_addr_o   = data_addr_i;
    mem_wdata_o  = data_wdata_i;
    mem_wmask_o  = '0;
    case (sel)
      SelInst: begin
        mem_valid_o  = inst_valid_i;
        inst_ready_o = mem_ready_i;
        mem_addr_o   = inst_addr_i;
        mem_wdata_o  = inst_wdata_i;
        mem_wmask_o  = inst_wmask_i;
      end
      SelData: begin
        mem_valid_o  = data_valid_i;
        data_ready_o = mem_ready_i;
        mem_addr_o   = data_addr_i;
        mem_wdata_o  = data_wdata_i;
        mem_wmask_o  = data_wmask_i;
      end
      default: ;
    endcase
    if (rst_i) begin
      mem_valid_o  = 1'b0;
      inst_ready_o = 1'b0;
      data_ready_o = 1'b0;
    end
  end

  assign accept           = mem_valid_o && mem_ready_i;
  assign have_outstanding = (count_q != '0);
  assign pop              = mem_rvalid_i && have_outstanding;
  assign head_owner       = owner_q[rd_ptr_q];

  assign inst_rdata_o  = mem_rdata_i;
  assign data_rdata_o  = mem_rdata_i;
  assign inst_rvalid_o = pop && !head_owner && !rst_i;
  assign data_rvalid_o = pop && head_owner && !rst_i;
  assign err_o         = err_q;

  always_comb begin
    hold_d   = hold_q;
    owner_d  = owner_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    starve_d = starve_q;
    err_d    = err_q;

    if (accept) begin
      owner_d[wr_ptr_q] = (sel == SelData);
      wr_ptr_d          = wr_ptr_q + 1'b1;
      hold_d            = HoldNone;
      if (sel == SelInst) begin
        starve_d = '0;
      end else if (inst_valid_i && (starve_q != '1)) begin
        starve_d = starve_q + 1'b1;
      end
    end else if (mem_valid_o) begin
      hold_d = (sel == SelInst) ? HoldInst : HoldData;
    end

    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end

    case ({accept, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    if (mem_rvalid_i && !have_outstanding) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hold_q   <= HoldNone;
      owner_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      starve_q <= '0;
      err_q    <= 1'b0;
    end else begin
      hold_q   <= hold_d;
      owner_q  <= owner_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      starve_q <= starve_d;
      err_q    <= err_d;
    end
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares one unified memory port between the core's instruction-fetch and data-access ports, so the Harvard core can run against a single von Neumann memory. Each side uses the core's valid/ready request and in-order rvalid response protocol. The block grants one request per cycle and holds a granted but stalled request stable. It records the owner of every outstanding transaction and routes each memory response back to the requester that issued it.

## Interface
- Xlen, 32, address width
- Ilen, 32, data width; mask width is Ilen/8
- OutstandingLog2, 2, log2 of the owner-tracker depth (4 outstanding transactions)
- StarveLimit, 4, consecutive data grants while an instruction request waits before instruction is forced a grant; range 1..15

- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- inst_valid_i / inst_ready_o  in/out  1  instruction request handshake
- inst_addr_i  in  Xlen; inst_wdata_i  in  Ilen; inst_wmask_i  in  Ilen/8  instruction request payload
- inst_rdata_o  out  Ilen; inst_rvalid_o  out  1  instruction response
- data_valid_i / data_ready_o, data_addr_i, data_wdata_i, data_wmask_i, data_rdata_o, data_rvalid_o: same as the instruction set, for the data side
- mem_valid_o  out  1; mem_ready_i  in  1  unified request handshake
- mem_addr_o  out  Xlen; mem_wdata_o  out  Ilen; mem_wmask_o  out  Ilen/8  request payload of the granted side
- mem_rdata_i  in  Ilen; mem_rvalid_i  in  1  unified response
- err_o  out  1  sticky protocol error

## Operation
- A request is accepted when mem_valid_o and mem_ready_i are both high. Memory returns exactly one mem_rvalid_i per accepted request, reads and writes alike, in order and no earlier than the cycle after acceptance.
- State is three items:
  - hold_q: 0=none, 1=inst, 2=data.
  - Owner FIFO: 2^OutstandingLog2 entries of 1 bit (0=inst, 1=data), with count.
  - starve_q: 4-bit counter.
- Grant selection, only when the tracker is not full:
  - If hold_q != none, the held side is selected, regardless of other valids.
  - Otherwise, if exactly one side is valid, that side is selected.
  - If both sides are valid, data is selected, unless starve_q == StarveLimit, in which case inst is selected.
- mem_valid_o = the selected side's valid. mem_addr_o, mem_wdata_o and mem_wmask_o come from the selected side. With no selection, the payload is don't-care and mem_wmask_o = 0.
- Ready: the selected side's ready = mem_ready_i; the other side's ready = 0. When the tracker is full, both readies and mem_valid_o are 0.
- On acceptance, push the owner bit and clear hold_q.
- If a side is selected but mem_ready_i is low, set hold_q to that side.
- Starvation counter:
  - A data grant while inst_valid_i is high increments starve_q, saturating.
  - An inst grant clears starve_q.
  - A data grant with inst_valid_i low leaves starve_q unchanged.
- Response: both rdata outputs = mem_rdata_i. inst_rvalid_o / data_rvalid_o = mem_rvalid_i qualified by the FIFO head owner, then the head is popped.
- mem_rvalid_i with an empty tracker: no rvalid is forwarded, err_o is set and stays set until reset.

## Timing
- Request path is combinational, with zero added latency. Response path is combinational, with zero added latency.
- Full FIFO blocks acceptance even if a pop occurs in the same cycle.
- Not full: a push and a pop in the same cycle are both performed and count is unchanged.
- Pointers wrap modulo the depth.
- Asynchronous reset clears hold_q, the FIFO, starve_q and err_o.
- While rst_i is high, all ready, valid and rvalid outputs are forced to 0.
- Reset in the middle of a transaction drops all outstanding ownership. Any later stray response raises err_o.
- A requester must hold valid and payload stable until accepted. The arbiter never changes the selected side while hold_q is set.

## Test plan
- Both valid, mem_ready_i high, StarveLimit=4 → data accepted for 4 cycles, starve_q goes 1..4, 5th grant goes to inst, starve_q back to 0.
- Inst selected with mem_ready_i low for 3 cycles while data_valid_i rises → mem_addr_o stays on the inst address and data_ready_o=0 throughout; the inst request is accepted when ready rises.
- Accept inst, data, inst (memory latency 2) → rvalids are routed inst, data, inst in order, rdata matches, err_o=0.
- Four requests accepted with no responses → fifth request sees mem_valid_o=0 and both readies 0. A response and a new request in the same cycle → no accept that cycle, accept on the next cycle.
- mem_rvalid_i pulsed at idle after reset → both rvalid outputs 0, err_o=1 and stays set until rst_i.
- Assert rst_i asynchronously between clock edges with 2 outstanding → outputs go to 0 immediately. After release, a new request is accepted, its response is routed correctly, and count=1 after the accept.
